// File: rtl/eproc_in_data_checker.sv
// Receive-side checker for data_generator frames: validates SOP/EOP delimiting and an incrementing payload.
// Optional macro DATA_CHECKER_LEN_CHECK_EN: EOP also requires exactly FRAME_LEN data bytes.
module eproc_in_data_checker #(
  parameter int CNT_W         = 16,
  parameter int MAX_FRAME_LEN = 255,
  parameter int LOCK_FRAMES   = 4,
  parameter int FRAME_LEN     = 16
) (
  input  logic             bitCLK,
  input  logic             rst,
  input  logic [9:0]       DATA_IN,
  input  logic             DATA_RDY,
  input  logic             enable,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] byte_err_cnt,
  output logic [CNT_W-1:0] frame_err_cnt,
  output logic             err_pulse,
  output logic             frame_done,
  output logic             in_frame,
  output logic             locked,
  output logic [7:0]       last_byte
);
  localparam int LEN_W = $clog2(MAX_FRAME_LEN + 1);
  localparam int RUN_W = $clog2(LOCK_FRAMES + 1);
  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_FRAME_LEN);
  localparam logic [RUN_W-1:0] LOCK_C    = RUN_W'(LOCK_FRAMES);

  localparam logic [1:0] C_DATA  = 2'b00;
  localparam logic [1:0] C_EOP   = 2'b01;
  localparam logic [1:0] C_SOP   = 2'b10;
  localparam logic [1:0] C_COMMA = 2'b11;

  if (FRAME_LEN < 1 || FRAME_LEN > MAX_FRAME_LEN) begin : g_bad_frame_len
    $error("FRAME_LEN must lie in 1..MAX_FRAME_LEN");
  end

  typedef enum logic {HUNT, FRAME} state_t;

  state_t           state;
  logic [LEN_W-1:0] byte_cnt;
  logic [7:0]       expected;
  logic             first_byte;
  logic             frame_dirty;
  logic [RUN_W-1:0] run_cnt;

  logic [1:0] code;
  logic [7:0] dbyte;
  logic       take;
  logic       len_ok;
  logic       byte_err;
  logic       frm_err;
  logic       close_ok;

  assign code     = DATA_IN[9:8];
  assign dbyte    = DATA_IN[7:0];
  assign take     = DATA_RDY & enable;
  assign in_frame = (state == FRAME);

`ifdef DATA_CHECKER_LEN_CHECK_EN
  localparam logic [LEN_W-1:0] FRAME_LEN_C = LEN_W'(FRAME_LEN);
  assign len_ok = (byte_cnt == FRAME_LEN_C);
`else
  assign len_ok = 1'b1;
`endif

  always_comb begin
    byte_err = 1'b0;
    frm_err  = 1'b0;
    close_ok = 1'b0;
    if (take) begin
      if (state == HUNT) begin
        frm_err = (code == C_DATA) || (code == C_EOP);
      end else begin
        case (code)
          C_DATA: begin
            byte_err = !first_byte && (dbyte != expected);
            frm_err  = (byte_cnt == MAX_LEN_C);
          end
          C_EOP: begin
            if (byte_cnt == '0 || !len_ok) frm_err = 1'b1;
            else                           close_ok = 1'b1;
          end
          C_SOP:   frm_err = 1'b1;
          default: ;
        endcase
      end
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge bitCLK) begin
    if (rst) begin
      state         <= HUNT;
      byte_cnt      <= '0;
      expected      <= '0;
      first_byte    <= 1'b1;
      frame_dirty   <= 1'b0;
      run_cnt       <= '0;
      frame_cnt     <= '0;
      byte_err_cnt  <= '0;
      frame_err_cnt <= '0;
      err_pulse     <= 1'b0;
      frame_done    <= 1'b0;
      locked        <= 1'b0;
      last_byte     <= 8'h00;
    end else begin
      err_pulse  <= byte_err | frm_err;
      frame_done <= close_ok;

      if (take && code != C_COMMA) begin
        if (state == HUNT) begin
          if (code == C_SOP) begin
            state       <= FRAME;
            byte_cnt    <= '0;
            first_byte  <= 1'b1;
            frame_dirty <= 1'b0;
          end
        end else begin
          case (code)
            C_DATA: begin
              last_byte   <= dbyte;
              expected    <= dbyte + 8'd1;
              first_byte  <= 1'b0;
              frame_dirty <= frame_dirty | byte_err;
              // The byte that would exceed the length limit ends the frame.
              if (byte_cnt == MAX_LEN_C) state <= HUNT;
              else                       byte_cnt <= byte_cnt + 1'b1;
            end
            C_EOP: state <= HUNT;
            C_SOP: begin
              byte_cnt    <= '0;
              first_byte  <= 1'b1;
              frame_dirty <= 1'b0;
            end
            default: ;
          endcase
        end
      end

      // A clear in the same cycle as a counted event drops the event.
      if (clr_cnt) begin
        frame_cnt     <= '0;
        byte_err_cnt  <= '0;
        frame_err_cnt <= '0;
        run_cnt       <= '0;
        locked        <= 1'b0;
      end else begin
        if (byte_err) byte_err_cnt  <= sat_inc(byte_err_cnt);
        if (frm_err)  frame_err_cnt <= sat_inc(frame_err_cnt);
        if (close_ok) frame_cnt     <= sat_inc(frame_cnt);
        if (byte_err || frm_err) begin
          run_cnt <= '0;
          locked  <= 1'b0;
        end else if (close_ok && !frame_dirty) begin
          if (run_cnt != LOCK_C)            run_cnt <= run_cnt + 1'b1;
          if (run_cnt >= LOCK_C - 1'b1)     locked  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_eproc_in_data_checker.sv
// Randomized and directed bench for eproc_in_data_checker against a word-level behavioural model.
module tb_eproc_in_data_checker;
  localparam int CNT_W = 4;
  localparam int MAXL  = 255;
  localparam int LOCKN = 4;
  localparam int FLEN  = 16;
  localparam int SAT   = (1 << CNT_W) - 1;
`ifdef DATA_CHECKER_LEN_CHECK_EN
  localparam bit LEN_CHK = 1'b1;
`else
  localparam bit LEN_CHK = 1'b0;
`endif

  localparam logic [1:0] DAT = 2'b00, EOP = 2'b01, SOP = 2'b10, COM = 2'b11;

  logic             bitCLK = 1'b0;
  logic             rst = 1'b1;
  logic [9:0]       DATA_IN = '0;
  logic             DATA_RDY = 1'b0;
  logic             enable = 1'b1;
  logic             clr_cnt = 1'b0;
  logic [CNT_W-1:0] frame_cnt, byte_err_cnt, frame_err_cnt;
  logic             err_pulse, frame_done, in_frame, locked;
  logic [7:0]       last_byte;

  eproc_in_data_checker #(
    .CNT_W(CNT_W), .MAX_FRAME_LEN(MAXL), .LOCK_FRAMES(LOCKN), .FRAME_LEN(FLEN)
  ) dut (
    .bitCLK(bitCLK), .rst(rst), .DATA_IN(DATA_IN), .DATA_RDY(DATA_RDY), .enable(enable),
    .clr_cnt(clr_cnt), .frame_cnt(frame_cnt), .byte_err_cnt(byte_err_cnt),
    .frame_err_cnt(frame_err_cnt), .err_pulse(err_pulse), .frame_done(frame_done),
    .in_frame(in_frame), .locked(locked), .last_byte(last_byte)
  );

  always #5 bitCLK = ~bitCLK;

  int n_chk = 0;
  int n_fail = 0;
  int n_errp = 0;
  int n_done = 0;
  int gap_c = 0;

  // behavioural model state
  bit m_inframe, m_dirty, m_locked, m_errp, m_done;
  int m_n, m_prev, m_run, m_fc, m_bec, m_fec, m_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_inframe = 0; m_dirty = 0; m_locked = 0; m_errp = 0; m_done = 0;
    m_n = 0; m_prev = -1; m_run = 0; m_fc = 0; m_bec = 0; m_fec = 0; m_last = 0;
  endtask

  function automatic int sat(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  task automatic model(input logic [1:0] c, input logic [7:0] b, input bit en, input bit clr);
    bit be, fe, ok;
    be = 0; fe = 0; ok = 0;
    if (en && c != COM) begin
      if (!m_inframe) begin
        if (c == SOP) begin m_inframe = 1; m_n = 0; m_prev = -1; m_dirty = 0; end
        else fe = 1;
      end else begin
        case (c)
          DAT: begin
            if (m_prev >= 0 && int'(b) != (m_prev + 1) % 256) be = 1;
            m_prev = int'(b);
            m_last = int'(b);
            m_n++;
            if (be) m_dirty = 1;
            if (m_n > MAXL) begin fe = 1; m_inframe = 0; end
          end
          EOP: begin
            if (m_n == 0 || (LEN_CHK && m_n != FLEN)) fe = 1;
            else ok = 1;
            m_inframe = 0;
          end
          default: begin fe = 1; m_n = 0; m_prev = -1; m_dirty = 0; end
        endcase
      end
    end
    m_errp = be | fe;
    m_done = ok;
    if (clr) begin
      m_fc = 0; m_bec = 0; m_fec = 0; m_run = 0; m_locked = 0;
    end else begin
      if (be) m_bec = sat(m_bec);
      if (fe) m_fec = sat(m_fec);
      if (ok) m_fc = sat(m_fc);
      if (be || fe) begin m_run = 0; m_locked = 0; end
      else if (ok && !m_dirty) begin
        m_run++;
        if (m_run >= LOCKN) m_locked = 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("frame_cnt", 32'(frame_cnt), m_fc);
    chk("byte_err_cnt", 32'(byte_err_cnt), m_bec);
    chk("frame_err_cnt", 32'(frame_err_cnt), m_fec);
    chk("in_frame", 32'(in_frame), 32'(m_inframe));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("last_byte", 32'(last_byte), m_last);
    chk("err_pulse", 32'(err_pulse), 32'(m_errp));
    chk("frame_done", 32'(frame_done), 32'(m_done));
  endtask

  // Called at #1 after a rising edge; leaves time at #1 after a rising edge.
  task automatic send(input logic [1:0] c, input logic [7:0] b, input int gap,
                      input bit en, input bit clr);
    DATA_IN = {c, b}; DATA_RDY = 1'b1; enable = en; clr_cnt = clr;
    @(posedge bitCLK); #1;
    DATA_RDY = 1'b0; enable = 1'b1; clr_cnt = 1'b0;
    model(c, b, en, clr);
    compare_all();
    if (err_pulse) n_errp++;
    if (frame_done) n_done++;
    repeat (gap) begin @(posedge bitCLK); #1; end
    if (gap > 0) begin
      chk("err_pulse_idle", 32'(err_pulse), 0);
      chk("frame_done_idle", 32'(frame_done), 0);
    end
  endtask

  task automatic w(input logic [1:0] c, input logic [7:0] b);
    send(c, b, gap_c, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge bitCLK); #1;
    rst = 1'b0;
    m_reset();
    compare_all();
  endtask

  logic [7:0] starts [4] = '{8'hF5, 8'hF0, 8'hF8, 8'hEF};
  int fec0;

  initial begin
    m_reset();
    repeat (2) @(posedge bitCLK);
    #1 rst = 1'b0;
    compare_all();

    // single clean frame, one word every 5 cycles
    gap_c = 4; n_done = 0;
    w(SOP, 8'h00);
    for (int i = 0; i < 16; i++) w(DAT, 8'(8'h10 + i));
    w(EOP, 8'h00);
    chk("t1_frame_cnt", 32'(frame_cnt), 1);
    chk("t1_byte_err", 32'(byte_err_cnt), 0);
    chk("t1_frame_err", 32'(frame_err_cnt), 0);
    chk("t1_done_pulses", n_done, 1);
    chk("t1_last_byte", 32'(last_byte), 32'h1F);

    // four clean frames crossing FF->00 reach lock
    do_reset();
    gap_c = 0;
    for (int f = 0; f < 4; f++) begin
      w(SOP, 8'h00);
      for (int i = 0; i < 16; i++) w(DAT, 8'(starts[f] + 8'(i)));
      w(EOP, 8'h00);
      if (f == 2) chk("t2_not_locked_yet", 32'(locked), 0);
    end
    chk("t2_locked", 32'(locked), 1);
    chk("t2_byte_err", 32'(byte_err_cnt), 0);

    // payload gap: one byte error, lock lost
    n_errp = 0;
    w(SOP, 8'h00);
    w(DAT, 8'h05); w(DAT, 8'h06); w(DAT, 8'h09); w(DAT, 8'h0A);
    w(EOP, 8'h00);
    chk("t3_byte_err", 32'(byte_err_cnt), 1);
    chk("t3_locked", 32'(locked), 0);
    chk("t3_err_pulses", n_errp, LEN_CHK ? 2 : 1);

    // delimiter errors with commas interleaved
    do_reset();
    w(EOP, 8'h00); w(COM, 8'hBC); w(SOP, 8'h00); w(COM, 8'h3C);
    w(SOP, 8'h00); w(COM, 8'hFF); w(EOP, 8'h00);
    chk("t4_frame_err", 32'(frame_err_cnt), 3);
    chk("t4_frame_cnt", 32'(frame_cnt), 0);

    // reset mid-frame, then clear colliding with an error
    w(SOP, 8'h00); w(DAT, 8'h40); w(DAT, 8'h41); w(DAT, 8'h42);
    do_reset();
    chk("t5_in_frame", 32'(in_frame), 0);
    chk("t5_last_byte", 32'(last_byte), 0);
    w(EOP, 8'h00);
    send(EOP, 8'h00, 0, 1'b1, 1'b1);
    chk("t5_clr_frame_err", 32'(frame_err_cnt), 0);

    // enable low: words ignored
    w(SOP, 8'h00);
    send(DAT, 8'h33, 0, 1'b0, 1'b0);
    send(EOP, 8'h00, 0, 1'b0, 1'b0);
    chk("t6_still_in_frame", 32'(in_frame), 1);
    w(DAT, 8'h70); w(EOP, 8'h00);

    // runaway frame: byte MAXL+1 ends the frame with a framing error
    fec0 = m_fec;
    w(SOP, 8'h00);
    for (int i = 0; i <= MAXL; i++) w(DAT, 8'(i));
    chk("t7_runaway_hunt", 32'(in_frame), 0);
    chk("t7_runaway_err", 32'(frame_err_cnt), (fec0 + 1 > SAT) ? SAT : fec0 + 1);
    w(EOP, 8'h00);

    // random traffic, counters saturate at this CNT_W
    for (int k = 0; k < 1500; k++) begin
      int r;
      logic [1:0] c;
      logic [7:0] b;
      r = int'($urandom_range(0, 99));
      b = 8'($urandom);
      if (r < 8) c = SOP;
      else if (r < 16) c = EOP;
      else if (r < 22) c = COM;
      else begin
        c = DAT;
        if (m_prev >= 0 && $urandom_range(0, 9) != 0) b = 8'(m_prev + 1);
      end
      send(c, b, int'($urandom_range(0, 2)), $urandom_range(0, 15) != 0,
           $urandom_range(0, 99) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
